multicycle_main_control: RTL and testbench

- Multi-cycle main control FSM for the RV32I subset (R-type, load, store, beq).
- Sequences each instruction through fetch/decode/execute/memory/writeback.
- Drives datapath mux selects and enables.
- Generates the 2-bit aluop that the downstream ALU control decoder expands, together with funct7/funct3, into the 4-bit ALU operation.
- Includes a memory-wait timeout that traps a hung bus.

---
 rtl/ctrl_pkg.sv | 42 ++++
 rtl/mem_wait_timer.sv | 33 +++
 rtl/multicycle_main_control.sv | 162 ++++++++++++++++
 tb/tb_multicycle_main_control.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle RV32I main control.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, supported opcodes, aluop codes, ALU B-source
// select encodings, and a helper that identifies the memory-wait states.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    DECODE,
    MEM_ADDR,
    MEM_READ,
    MEM_WB,
    MEM_WRITE,
    EXEC_R,
    R_WB,
    BRANCH,
    TRAP,
    FAULT
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States that wait on mem_ready and are therefore guarded by the timer.
  function automatic logic is_mem_wait(state_t s);
    return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts stalled cycles in a memory-wait state and flags when the limit is hit.
// Latency: expired is combinational from the registered count.
// Backpressure: none; count saturates at the limit, clear has priority.
//
// Ports: clk, rst_n (async active-low), clear (restart count), count_en
// (one stalled cycle), expired (count == MEM_TIMEOUT, never when 0).
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  logic [TMR_W-1:0] cnt;

  // A limit of zero disables the watchdog entirely.
  assign expired = (MEM_TIMEOUT != 0) && (cnt == TMR_W'(MEM_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count_en && !expired) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/multicycle_main_control.sv
// Multi-cycle main control FSM for RV32I R-type/load/store/beq.
// Latency: R 4, load 5, store 4, beq 3 cycles with zero memory wait.
// Backpressure: stalls in FETCH/MEM_READ/MEM_WRITE until mem_ready; timeout -> FAULT.
//
// Ports: clk, rst_n, run (sequencing enable), opcode (from IR), mem_ready;
// datapath controls aluop, alu_src_a/b, mem_read/write, iord, ir_write,
// pc_write, pc_write_cond, reg_write, mem_to_reg; status instr_done,
// illegal_instr, bus_error.
module multicycle_main_control
  import ctrl_pkg::*;
#(
  parameter int N           = 4,
  parameter int MEM_TIMEOUT = 15,
  parameter int TMR_W       = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic [6:0]   opcode,
  input  logic         mem_ready,
  output logic [N-3:0] aluop,
  output logic         alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic         mem_read,
  output logic         mem_write,
  output logic         iord,
  output logic         ir_write,
  output logic         pc_write,
  output logic         pc_write_cond,
  output logic         reg_write,
  output logic         mem_to_reg,
  output logic         instr_done,
  output logic         illegal_instr,
  output logic         bus_error
);

  localparam int AW = N - 2;

  state_t state;
  state_t state_nxt;
  logic   tmr_expired;
  logic   tmr_clear;
  logic   tmr_count;

  // Restart the timer whenever the state changes so every wait state sees a
  // fresh budget, including back-to-back FETCHes across instructions.
  assign tmr_clear = (state_nxt != state) || !is_mem_wait(state);
  assign tmr_count = is_mem_wait(state) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TMR_W       (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (tmr_clear),
    .count_en (tmr_count),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (run) state_nxt = FETCH;
      FETCH: begin
        if (mem_ready)        state_nxt = DECODE;
        else if (tmr_expired) state_nxt = FAULT;
      end
      DECODE: begin
        case (opcode)
          OP_R:               state_nxt = EXEC_R;
          OP_LOAD, OP_STORE:  state_nxt = MEM_ADDR;
          OP_BRANCH:          state_nxt = BRANCH;
          default:            state_nxt = TRAP;
        endcase
      end
      MEM_ADDR:  state_nxt = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      MEM_READ: begin
        if (mem_ready)        state_nxt = MEM_WB;
        else if (tmr_expired) state_nxt = FAULT;
      end
      MEM_WRITE: begin
        if (mem_ready)        state_nxt = run ? FETCH : IDLE;
        else if (tmr_expired) state_nxt = FAULT;
      end
      MEM_WB, R_WB, BRANCH: state_nxt = run ? FETCH : IDLE;
      EXEC_R:    state_nxt = R_WB;
      TRAP:      state_nxt = IDLE;
      FAULT:     if (!run) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Moore decode; only FETCH's IR/PC load and the store retirement pulse
  // follow mem_ready within the cycle.
  always_comb begin
    aluop         = AW'(ALUOP_ADD);
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RS2;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    instr_done    = 1'b0;
    illegal_instr = 1'b0;
    bus_error     = 1'b0;
    case (state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      DECODE:    alu_src_b = SRCB_IMM;
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        aluop     = AW'(ALUOP_FUNCT);
      end
      R_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = AW'(ALUOP_SUB);
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      TRAP:      illegal_instr = 1'b1;
      FAULT:     bus_error = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_main_control.sv
module tb_multicycle_main_control;

  localparam logic [6:0] C_R   = 7'b0110011;
  localparam logic [6:0] C_LD  = 7'b0000011;
  localparam logic [6:0] C_ST  = 7'b0100011;
  localparam logic [6:0] C_BR  = 7'b1100011;
  localparam logic [6:0] C_ILL = 7'b1111111;
  localparam int         TO    = 15;

  logic       clk = 1'b0;
  logic       rst_n, run, mem_ready;
  logic [6:0] opcode;
  logic [1:0] aluop;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
  logic       reg_write, mem_to_reg, instr_done, illegal_instr, bus_error;
  logic [15:0] outv;

  int  checks = 0;
  int  errors = 0;
  bit  at_idle;

  always #5 clk = ~clk;

  multicycle_main_control dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .aluop(aluop), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .reg_write(reg_write),
    .mem_to_reg(mem_to_reg), .instr_done(instr_done),
    .illegal_instr(illegal_instr), .bus_error(bus_error)
  );

  assign outv = {aluop, alu_src_a, alu_src_b, mem_read, mem_write, iord, ir_write,
                 pc_write, pc_write_cond, reg_write, mem_to_reg, instr_done,
                 illegal_instr, bus_error};

  // Expected control word per instruction phase, straight from the output table.
  function automatic logic [15:0] ov(input logic [1:0] aop, input logic sa,
      input logic [1:0] sb, input logic mrd, input logic mwr, input logic io,
      input logic irw, input logic pcw, input logic pcc, input logic rw,
      input logic m2r, input logic dn, input logic ill, input logic be);
    return {aop, sa, sb, mrd, mwr, io, irw, pcw, pcc, rw, m2r, dn, ill, be};
  endfunction

  function automatic logic [15:0] e_fetch(input logic r);
    return ov(2'b00, 0, 2'b01, 1, 0, 0, r, r, 0, 0, 0, 0, 0, 0);
  endfunction
  function automatic logic [15:0] e_decode();  return ov(2'b00,0,2'b10,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [15:0] e_memaddr(); return ov(2'b00,1,2'b10,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [15:0] e_memrd();   return ov(2'b00,0,2'b00,1,0,1,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [15:0] e_memwb();   return ov(2'b00,0,2'b00,0,0,0,0,0,0,1,1,1,0,0); endfunction
  function automatic logic [15:0] e_memwr(input logic r);
    return ov(2'b00, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, r, 0, 0);
  endfunction
  function automatic logic [15:0] e_exec();    return ov(2'b10,1,2'b00,0,0,0,0,0,0,0,0,0,0,0); endfunction
  function automatic logic [15:0] e_rwb();     return ov(2'b00,0,2'b00,0,0,0,0,0,0,1,0,1,0,0); endfunction
  function automatic logic [15:0] e_branch();  return ov(2'b01,1,2'b00,0,0,0,0,0,1,0,0,1,0,0); endfunction
  function automatic logic [15:0] e_trap();    return ov(2'b00,0,2'b00,0,0,0,0,0,0,0,0,0,1,0); endfunction
  function automatic logic [15:0] e_fault();   return 16'h0001; endfunction
  function automatic logic [15:0] e_idle();    return 16'h0000; endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the edge, compare on the falling edge.
  task automatic step(input logic mr, input logic rn, input logic [15:0] exp, input string nm);
    mem_ready = mr;
    run       = rn;
    @(negedge clk);
    check(nm, outv, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_fault();
    int k;
    k = $urandom_range(1, 3);
    for (int i = 0; i < k; i++) step(rb(), 1'b1, e_fault(), "fault_hold");
    step(rb(), 1'b0, e_fault(), "fault_exit");
    at_idle = 1;
  endtask

  // Wait w cycles with mem_ready low, then complete, unless w exceeds the
  // timeout budget (TO+1 stalled cycles), in which case a fault follows.
  task automatic mem_wait(input int w, input logic [15:0] ew, input logic [15:0] ed,
                          input logic done_run, input string nm, output bit f);
    int n;
    f = 0;
    n = (w > TO) ? TO + 1 : w;
    for (int i = 0; i < n; i++) step(1'b0, rb(), ew, {nm, "_wait"});
    if (w > TO) begin
      finish_fault();
      f = 1;
    end else begin
      step(1'b1, done_run, ed, nm);
    end
  endtask

  // Instruction-level reference: expected phase sequence per opcode class.
  task automatic do_instr(input logic [6:0] op, input int fw, input int mw, input logic ra);
    bit f;
    opcode = op;
    if (at_idle) step(rb(), 1'b1, e_idle(), "idle_start");
    at_idle = 0;
    mem_wait(fw, e_fetch(1'b0), e_fetch(1'b1), rb(), "fetch", f);
    if (f) return;
    step(rb(), rb(), e_decode(), "decode");
    if (op == C_R) begin
      step(rb(), rb(), e_exec(), "exec_r");
      step(rb(), ra, e_rwb(), "r_wb");
    end else if (op == C_LD) begin
      step(rb(), rb(), e_memaddr(), "ld_addr");
      mem_wait(mw, e_memrd(), e_memrd(), rb(), "mem_read", f);
      if (f) return;
      step(rb(), ra, e_memwb(), "mem_wb");
    end else if (op == C_ST) begin
      step(rb(), rb(), e_memaddr(), "st_addr");
      mem_wait(mw, e_memwr(1'b0), e_memwr(1'b1), ra, "mem_write", f);
      if (f) return;
    end else if (op == C_BR) begin
      step(rb(), ra, e_branch(), "branch");
    end else begin
      step(rb(), rb(), e_trap(), "trap");
      at_idle = 1;
      return;
    end
    at_idle = !ra;
  endtask

  typedef struct {
    logic        rn;
    logic        mr;
    logic [6:0]  op;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [6:0] rop;
    int         k;

    rst_n = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = C_R;
    repeat (3) begin
      @(negedge clk);
      check("reset_outputs", outv, e_idle());
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Starts in FETCH: R-type, branch dropping run, illegal, then R to IDLE.
    tbl.push_back(vec_t'{1'b1, 1'b1, C_R,   e_fetch(1'b1)});
    tbl.push_back(vec_t'{1'b0, 1'b0, C_R,   e_decode()});
    tbl.push_back(vec_t'{1'b0, 1'b1, C_R,   e_exec()});
    tbl.push_back(vec_t'{1'b1, 1'b0, C_R,   e_rwb()});
    tbl.push_back(vec_t'{1'b1, 1'b1, C_BR,  e_fetch(1'b1)});
    tbl.push_back(vec_t'{1'b1, 1'b0, C_BR,  e_decode()});
    tbl.push_back(vec_t'{1'b0, 1'b1, C_BR,  e_branch()});
    tbl.push_back(vec_t'{1'b0, 1'b1, C_BR,  e_idle()});
    tbl.push_back(vec_t'{1'b1, 1'b0, C_ILL, e_idle()});
    tbl.push_back(vec_t'{1'b1, 1'b1, C_ILL, e_fetch(1'b1)});
    tbl.push_back(vec_t'{1'b1, 1'b0, C_ILL, e_decode()});
    tbl.push_back(vec_t'{1'b1, 1'b1, C_ILL, e_trap()});
    tbl.push_back(vec_t'{1'b1, 1'b0, C_ILL, e_idle()});
    tbl.push_back(vec_t'{1'b1, 1'b0, C_R,   e_fetch(1'b0)});
    tbl.push_back(vec_t'{1'b1, 1'b1, C_R,   e_fetch(1'b1)});
    tbl.push_back(vec_t'{1'b1, 1'b1, C_R,   e_decode()});
    tbl.push_back(vec_t'{1'b1, 1'b0, C_R,   e_exec()});
    tbl.push_back(vec_t'{1'b0, 1'b1, C_R,   e_rwb()});
    foreach (tbl[i]) begin
      opcode = tbl[i].op;
      step(tbl[i].mr, tbl[i].rn, tbl[i].exp, $sformatf("tbl%0d", i));
    end
    at_idle = 1;

    // Directed multi-cycle corners.
    do_instr(C_LD, 0, 3, 1'b1);     // load with 3 wait cycles in MEM_READ
    do_instr(C_ST, 1, 2, 1'b0);     // store, drops run at retirement
    do_instr(C_R, TO + 1, 0, 1'b1); // FETCH timeout -> FAULT
    do_instr(C_R, TO, 0, 1'b1);     // ready on the last allowed cycle wins
    do_instr(C_LD, 0, TO + 1, 1'b1);
    do_instr(C_ST, 0, TO + 1, 1'b0);
    do_instr(C_ST, 0, TO, 1'b1);

    // Reset asserted while a store is waiting in MEM_WRITE.
    opcode = C_ST;
    if (at_idle) step(1'b0, 1'b1, e_idle(), "idle_start");
    step(1'b1, 1'b1, e_fetch(1'b1), "rst_fetch");
    step(1'b0, 1'b1, e_decode(), "rst_decode");
    step(1'b0, 1'b1, e_memaddr(), "rst_addr");
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset_async", outv, e_idle());
    @(negedge clk);
    check("reset_held", outv, e_idle());
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    at_idle = 0;
    step(1'b1, 1'b1, e_fetch(1'b1), "post_reset_fetch");
    step(1'b0, 1'b1, e_decode(), "post_reset_decode");
    step(1'b0, 1'b1, e_memaddr(), "post_reset_addr");
    step(1'b1, 1'b1, e_memwr(1'b1), "post_reset_store");

    // Random instruction stream.
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 4);
      case (k)
        0: rop = C_R;
        1: rop = C_LD;
        2: rop = C_ST;
        3: rop = C_BR;
        default: begin
          rop = 7'($urandom);
          while (rop == C_R || rop == C_LD || rop == C_ST || rop == C_BR)
            rop = 7'($urandom);
        end
      endcase
      do_instr(rop,
               ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(0, 3),
               ($urandom_range(0, 11) == 0) ? TO + 1 : $urandom_range(0, 3),
               ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
